// File: rtl/ipf_pkg.sv
// Shared IPF definitions: LCU size encoding, frame geometry and LCU walk helpers.
package ipf_pkg;

    localparam int IMG_W = 128;
    localparam int AW    = 14;

    localparam logic [1:0] LCU16   = 2'd0;
    localparam logic [1:0] LCU32   = 2'd1;
    localparam logic [1:0] LCU64   = 2'd2;
    localparam logic [1:0] LCU_BAD = 2'd3;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_RUN,
        FEED_DRAIN,
        FEED_DONE
    } feed_state_e;

    // Position inside the frame walk: LCU index, then row/col inside the LCU.
    typedef struct packed {
        logic [2:0] lx;
        logic [2:0] ly;
        logic [5:0] r;
        logic [5:0] c;
    } lcu_pos_t;

    function automatic logic [6:0] lcu_n(input logic [1:0] size);
        return 7'd16 << size;
    endfunction

    function automatic logic [3:0] lcu_l(input logic [1:0] size);
        return 4'd8 >> size;
    endfunction

    function automatic logic pos_last(input lcu_pos_t p, input logic [1:0] size);
        logic [5:0] nm1;
        logic [2:0] lm1;
        nm1 = 6'(lcu_n(size) - 7'd1);
        lm1 = 3'(lcu_l(size) - 4'd1);
        return (p.c == nm1) && (p.r == nm1) && (p.lx == lm1) && (p.ly == lm1);
    endfunction

    // Raster within the LCU, then LCU raster; wraps to zero after the last pixel.
    function automatic lcu_pos_t pos_next(input lcu_pos_t p, input logic [1:0] size);
        lcu_pos_t   q;
        logic [5:0] nm1;
        logic [2:0] lm1;
        q   = p;
        nm1 = 6'(lcu_n(size) - 7'd1);
        lm1 = 3'(lcu_l(size) - 4'd1);
        if (p.c != nm1) begin
            q.c = p.c + 6'd1;
        end else begin
            q.c = '0;
            if (p.r != nm1) begin
                q.r = p.r + 6'd1;
            end else begin
                q.r = '0;
                if (p.lx != lm1) begin
                    q.lx = p.lx + 3'd1;
                end else begin
                    q.lx = '0;
                    q.ly = (p.ly != lm1) ? p.ly + 3'd1 : 3'd0;
                end
            end
        end
        return q;
    endfunction

    function automatic logic [AW-1:0] pos_addr(input lcu_pos_t p, input logic [1:0] size);
        logic [6:0] row;
        logic [6:0] col;
        row = (lcu_n(size) * {4'b0, p.ly}) + {1'b0, p.r};
        col = (lcu_n(size) * {4'b0, p.lx}) + {1'b0, p.c};
        return {row, col};
    endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry 8-bit FIFO holding prefetched image pixels ahead of the IPF port.
module pix_skid_fifo (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    logic [7:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    // A push while full is only legal together with a pop; the write then
    // lands in the slot being vacated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/lcu_pixel_feeder.sv
// Streams a 128x128 image from SRAM to the IPF one LCU at a time, honouring busy.
module lcu_pixel_feeder
    import ipf_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [1:0]    cfg_lcu_size_i,
    output logic          img_rd_o,
    output logic [AW-1:0] img_addr_o,
    input  logic [7:0]    img_q_i,
    input  logic          busy_i,
    output logic          in_en_o,
    output logic [7:0]    din_o,
    output logic [2:0]    lcu_x_o,
    output logic [2:0]    lcu_y_o,
    output logic [1:0]    lcu_size_o,
    output logic          feed_busy_o,
    output logic          feed_done_o,
    output logic          cfg_err_o
);

    feed_state_e state_q, state_d;
    logic [1:0]  size_q, size_d;
    lcu_pos_t    rd_pos_q, rd_pos_d;
    lcu_pos_t    hd_pos_q, hd_pos_d;
    logic        rd_inflight_q;
    logic        cfg_err_q, cfg_err_d;

    logic        start_ok, start_bad;
    logic        issue, xfer, head_valid;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]  fifo_count;
    logic [7:0]  fifo_head;

    assign start_ok  = (state_q == FEED_IDLE) && start_i && (cfg_lcu_size_i != LCU_BAD);
    assign start_bad = (state_q == FEED_IDLE) && start_i && (cfg_lcu_size_i == LCU_BAD);

    // Reads in flight count against FIFO space so landing data always fits.
    assign issue = (state_q == FEED_RUN) && !fifo_full
                   && (2'(fifo_count + 2'(rd_inflight_q)) < 2'd2);

    // Data returning from SRAM is presented directly when the FIFO is empty.
    assign head_valid = !fifo_empty || rd_inflight_q;
    assign xfer       = head_valid && !busy_i;
    assign fifo_pop   = xfer && !fifo_empty;
    assign fifo_push  = rd_inflight_q && !(xfer && fifo_empty);

    pix_skid_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (img_q_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= FEED_IDLE;
            size_q        <= LCU16;
            rd_pos_q      <= '0;
            hd_pos_q      <= '0;
            rd_inflight_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            size_q        <= size_d;
            rd_pos_q      <= rd_pos_d;
            hd_pos_q      <= hd_pos_d;
            rd_inflight_q <= issue;
            cfg_err_q     <= cfg_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        feed_busy_o = 1'b0;
        feed_done_o = 1'b0;
        case (state_q)
            FEED_IDLE: begin
                if (start_ok) state_d = FEED_RUN;
            end
            FEED_RUN: begin
                feed_busy_o = 1'b1;
                if (issue && pos_last(rd_pos_q, size_q)) state_d = FEED_DRAIN;
            end
            FEED_DRAIN: begin
                feed_busy_o = 1'b1;
                if (xfer && pos_last(hd_pos_q, size_q)) state_d = FEED_DONE;
            end
            FEED_DONE: begin
                feed_done_o = 1'b1;
                state_d     = FEED_IDLE;
            end
            default: state_d = FEED_IDLE;
        endcase
    end

    always_comb begin
        size_d    = size_q;
        rd_pos_d  = rd_pos_q;
        hd_pos_d  = hd_pos_q;
        cfg_err_d = start_bad;
        if (start_ok) begin
            size_d   = cfg_lcu_size_i;
            rd_pos_d = '0;
            hd_pos_d = '0;
        end else begin
            if (issue) rd_pos_d = pos_next(rd_pos_q, size_q);
            if (xfer)  hd_pos_d = pos_next(hd_pos_q, size_q);
        end
    end

    assign img_rd_o   = issue;
    assign img_addr_o = pos_addr(rd_pos_q, size_q);
    assign in_en_o    = xfer;
    assign din_o      = !fifo_empty ? fifo_head : (rd_inflight_q ? img_q_i : 8'h00);
    assign lcu_x_o    = hd_pos_q.lx;
    assign lcu_y_o    = hd_pos_q.ly;
    assign lcu_size_o = size_q;
    assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_lcu_pixel_feeder.sv
// Randomized-stall bench for lcu_pixel_feeder against a loop-based frame order model.
module tb_lcu_pixel_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  cfg_size;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_q = 8'h00;
    logic        busy;
    logic        in_en;
    logic [7:0]  din;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        feed_busy;
    logic        feed_done;
    logic        cfg_err;

    logic [7:0]  mem [16384];
    logic [13:0] exp_addr [16384];
    int          exp_lx [16384];
    int          exp_ly [16384];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (img_rd) img_q <= mem[img_addr];

    lcu_pixel_feeder dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .cfg_lcu_size_i (cfg_size),
        .img_rd_o       (img_rd),
        .img_addr_o     (img_addr),
        .img_q_i        (img_q),
        .busy_i         (busy),
        .in_en_o        (in_en),
        .din_o          (din),
        .lcu_x_o        (lcu_x),
        .lcu_y_o        (lcu_y),
        .lcu_size_o     (lcu_size),
        .feed_busy_o    (feed_busy),
        .feed_done_o    (feed_done),
        .cfg_err_o      (cfg_err)
    );

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        logic [13:0] aa;
        aa = 14'(a);
        return aa[7:0] ^ {2'b00, aa[13:8]};
    endfunction

    task automatic check_reset_outputs(input string where);
        chk({where, ".img_rd"},    int'(img_rd),    0);
        chk({where, ".img_addr"},  int'(img_addr),  0);
        chk({where, ".in_en"},     int'(in_en),     0);
        chk({where, ".din"},       int'(din),       0);
        chk({where, ".lcu_x"},     int'(lcu_x),     0);
        chk({where, ".lcu_y"},     int'(lcu_y),     0);
        chk({where, ".lcu_size"},  int'(lcu_size),  0);
        chk({where, ".feed_busy"}, int'(feed_busy), 0);
        chk({where, ".feed_done"}, int'(feed_done), 0);
        chk({where, ".cfg_err"},   int'(cfg_err),   0);
    endtask

    // mode 0: busy low; 1: random busy plus 500-cycle bursts at LCU ends and
    // a stray start; 2: busy toggling. abort_at >= 0 stops after that many transfers.
    task automatic run_frame(input logic [1:0] size, input int mode, input int abort_at);
        int n, l, nn, k, rel, changes, done_rel, burst, budget;
        bit seen_rd, aborted;
        logic [2:0] px, py;
        n  = 16 << size;
        l  = 128 / n;
        nn = n * n;
        k  = 0;
        for (int ly = 0; ly < l; ly++)
            for (int lx = 0; lx < l; lx++)
                for (int r = 0; r < n; r++)
                    for (int c = 0; c < n; c++) begin
                        exp_addr[k] = 14'((ly * n + r) * 128 + lx * n + c);
                        exp_lx[k]   = lx;
                        exp_ly[k]   = ly;
                        k++;
                    end
        k = 0; rel = 1; changes = 0; done_rel = -1; burst = 0;
        seen_rd = 1'b0; aborted = 1'b0;
        budget = (mode == 0) ? 20000 : 60000;
        px = lcu_x; py = lcu_y;
        cfg_size = size; start = 1'b1; busy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            @(negedge clk);
            if (rel == 1) chk("feed_busy_after_start", int'(feed_busy), 1);
            if (img_rd && !seen_rd) begin
                seen_rd = 1'b1;
                chk("first_rd_cycle", rel, 1);
                chk("first_rd_addr", int'(img_addr), 0);
            end
            if (busy) chk("in_en_while_busy", int'(in_en), 0);
            if (in_en) begin
                if (k >= 16384) begin
                    chk("extra_transfer", k, 16383);
                    break;
                end
                if (k == 0 && mode == 0) chk("first_xfer_cycle", rel, 2);
                chk($sformatf("din[%0d]", k), int'(din), int'(mem[exp_addr[k]]));
                chk($sformatf("lcu_x[%0d]", k), int'(lcu_x), exp_lx[k]);
                chk($sformatf("lcu_y[%0d]", k), int'(lcu_y), exp_ly[k]);
                if (size == 2'd0 && k == 16) chk("t16_row1", int'(din), int'(pat(128)));
                if (size == 2'd2 && k == 64) chk("t64_row1", int'(din), int'(pat(128)));
                if (size == 2'd2 && k == 4096) begin
                    chk("t4096_din", int'(din), int'(pat(64)));
                    chk("t4096_lcu_x", int'(lcu_x), 1);
                    chk("t4096_lcu_y", int'(lcu_y), 0);
                end
                if (mode == 1 && (k % nn) == nn - 1) burst = 500;
                k++;
            end
            if (lcu_x != px || lcu_y != py) changes++;
            px = lcu_x; py = lcu_y;
            if (feed_done) begin
                done_rel = rel;
                break;
            end
            if (abort_at >= 0 && k >= abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (rel >= budget) begin
                chk("done_within_budget", int'(feed_done), 1);
                break;
            end
            @(posedge clk); #1;
            rel++;
            if (mode == 1 && rel == 1000) begin
                start = 1'b1; cfg_size = 2'd0;
            end else begin
                start = 1'b0; cfg_size = size;
            end
            case (mode)
                1: begin
                    if (burst > 0) begin
                        busy = 1'b1;
                        burst--;
                    end else begin
                        busy = 1'($urandom_range(0, 1));
                    end
                end
                2:       busy = ~busy;
                default: busy = 1'b0;
            endcase
        end
        start = 1'b0; cfg_size = size;
        if (aborted) begin
            $display("frame size=%0d mode=%0d aborted after %0d transfers", size, mode, k);
        end else begin
            chk("xfer_count", k, 16384);
            if (mode == 0) chk("done_cycle", done_rel, 16386);
            chk("lcu_changes", changes, l * l);
            chk("lcu_size_latched", int'(lcu_size), int'(size));
            $display("frame size=%0d mode=%0d transfers=%0d done_at=E+%0d lcu_changes=%0d",
                     size, mode, k, done_rel, changes);
            @(posedge clk); #1;
            busy = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = pat(a);
        rst_n = 1'b0; start = 1'b0; cfg_size = 2'd0; busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_frame(2'd0, 0, -1);
        run_frame(2'd1, 1, -1);

        cfg_size = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_size = 2'd0;
        @(negedge clk);
        chk("cfg_err_pulse", int'(cfg_err), 1);
        chk("cfg_err_no_rd", int'(img_rd), 0);
        chk("cfg_err_stays_idle", int'(feed_busy), 0);
        chk("cfg_err_size_kept", int'(lcu_size), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cfg_err_one_cycle", int'(cfg_err), 0);
        chk("cfg_err_still_no_rd", int'(img_rd), 0);
        chk("cfg_err_still_idle", int'(feed_busy), 0);
        $display("illegal size start: cfg_err=%0d feed_busy=%0d", cfg_err, feed_busy);
        @(posedge clk); #1;

        run_frame(2'd2, 2, 5000);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        @(posedge clk); #1;
        busy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(2'd2, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcu_pixel_feeder.md
# lcu_pixel_feeder

Upstream stage of the IPF filter. Reads a 128x128 8-bit source image from a synchronous-read image SRAM and streams it to the IPF input port (`in_en`/`din`) one LCU at a time, in LCU raster order, pixel raster order within each LCU. It drives the per-LCU coordinates and size that the IPF samples, and honours the IPF `busy` back-pressure without losing or duplicating pixels.

## Interface
- `IMG_W`, 128: image width and height in pixels (fixed square frame).
- `AW`, 14: image address width; address = row*128 + col.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle frame-start pulse; honoured only in IDLE.
- `cfg_lcu_size` input 2: 0=16x16, 1=32x32, 2=64x64; 3 is illegal. Sampled with `start`.
- `img_rd` output 1: SRAM read strobe.
- `img_addr` output 14: SRAM read address.
- `img_q` input 8: SRAM read data, valid exactly 1 cycle after `img_rd`.
- `busy` input 1: IPF back-pressure; no transfer in any cycle where it is high.
- `in_en` output 1: pixel valid to IPF; a transfer occurs in every cycle `in_en`=1.
- `din` output 8: pixel value.
- `lcu_x`, `lcu_y` output 3: LCU index of the pixel on `din`.
- `lcu_size` output 2: latched `cfg_lcu_size`.
- `feed_busy` output 1: high from accepted `start` until `feed_done`.
- `feed_done` output 1: one-cycle pulse after the last pixel transfer.
- `cfg_err` output 1: one-cycle pulse when `start` arrives with `cfg_lcu_size`=3.

## Operation
- N = 16<<lcu_size; LCUs per side L = 8>>lcu_size; pixels per LCU = N*N; frame = 16384 pixels for all sizes.
- Order: `lcu_y` outer, `lcu_x` inner; within LCU, row r outer, col c inner. Address = ((lcu_y*N + r)<<7) | (lcu_x*N + c).
- Two independent counter sets: read side (address generator) and head side (coordinates of the pixel presented on `din`). `lcu_x`/`lcu_y` follow the head side.
- Prefetch buffer: 2-entry FIFO for `img_q`. Issue `img_rd` only when (FIFO occupancy + reads in flight) < 2 and read addresses remain.
- `in_en` = FIFO non-empty AND NOT `busy` (combinational gate on `busy`); `din` = FIFO head. Pop on transfer.
- FSM: IDLE -> RUN on `start` with legal size (latch size, clear counters). RUN -> DRAIN when last address issued. DRAIN -> DONE when last pixel transferred. DONE (one cycle, `feed_done`=1) -> IDLE.
- `start` outside IDLE is ignored. `start` with size 3 in IDLE: stay IDLE, pulse `cfg_err`, `lcu_size` unchanged.
- Simultaneous push and pop on a full FIFO is legal; occupancy unchanged.

## Timing
- Reset values: `img_rd`=0, `img_addr`=0, `in_en`=0, `din`=0, `lcu_x`=0, `lcu_y`=0, `lcu_size`=0, `feed_busy`=0, `feed_done`=0, `cfg_err`=0; FIFO empty, FSM IDLE.
- `start` sampled at edge E; first `img_rd` (addr 0) in cycle E+1; first `in_en` earliest in E+2.
- With `busy` held low, one transfer per cycle from E+2. The last transfer is in cycle E+16385, and `feed_done` is high in E+16386.
- `busy` rising: `in_en` drops in the same cycle. The read already in flight lands in the FIFO, so no data is lost.
- `lcu_x`/`lcu_y` advance in the cycle after the last pixel of an LCU transfers.
- Reset asserted mid-frame: all state cleared asynchronously and in-flight read data discarded. The next `start` restarts at pixel 0.

## Structure
- Shared package `ipf_pkg`: lcu_size encoding constants (LCU16/32/64), `IMG_W`, address width, and the helpers N(size) and L(size). Shared with IPF.
- One sub-module: `pix_skid_fifo` (2-entry, 8-bit, push/pop/full/empty/count).
- FSM, read counters, head counters and gating logic stay in the top module.

## Test plan
- Size 0, `busy`=0, mem[a]=a[7:0]^a[13:8]: 16384 transfers, first `in_en` at E+2. Transfer 16 carries mem[128]. `lcu_x` becomes 1 after transfer 255. `feed_done` at E+16386.
- Size 2, `busy`=0: transfer 64 (row 1) carries mem[128]. Transfer 4096 carries mem[64] with `lcu_x`=1, `lcu_y`=0. Exactly 4 LCU changes.
- Size 1 with random `busy` (50%) plus 500-cycle `busy` bursts at each LCU boundary: the transfer sequence is identical to the no-stall run, with no `in_en` while `busy`=1.
- `cfg_lcu_size`=3 with `start`: `cfg_err` pulse, no `img_rd`, FSM stays IDLE. A second `start` during RUN is ignored (transfer count stays 16384).
- `reset` asserted at transfer 5000 with `busy` toggling: all outputs return to reset values. A new `start` begins at address 0 and completes normally.
